// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns a load/store op into one bus request, then aligns and extends the load data.
// Optional build macro MEM_MISALIGN_EXC_EN: misaligned accesses complete at once with out_misalign=1 and no bus traffic.
module mem_access_unit #(
   parameter  int XLEN = 64,
   localparam int SBW  = XLEN / 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_read,
   input  logic            in_write,
   input  logic [1:0]      in_size,
   input  logic            in_unsigned,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   output logic            bus_req_valid,
   input  logic            bus_req_ready,
   output logic            bus_req_write,
   output logic [XLEN-1:0] bus_req_addr,
   output logic [1:0]      bus_req_size,
   output logic [XLEN-1:0] bus_req_data,
   output logic [SBW-1:0]  bus_req_strobe,
   input  logic            bus_resp_valid,
   input  logic [XLEN-1:0] bus_resp_data,
   output logic            out_valid,
   output logic [XLEN-1:0] out_rdata,
   output logic            out_misalign,
   output logic            stall,
   output logic [1:0]      dbg_state
);

   localparam int OFFW = $clog2(SBW);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state;
   logic            mem_op;
   logic            mis;
   logic [1:0]      eff_size;
   logic [OFFW-1:0] in_off;
   logic [OFFW-1:0] req_off;
   logic [2*SBW-1:0] byte_mask;
   logic [2*SBW-1:0] shifted_mask;
   logic [SBW-1:0]  cap_strobe;
   logic [XLEN-1:0] cap_data;
   logic [XLEN-1:0] resp_shift;
   logic [XLEN-1:0] load_ext;

   logic [XLEN-1:0] req_addr;
   logic [1:0]      req_size;
   logic            req_unsigned;
   logic            req_write;
   logic [XLEN-1:0] req_data;
   logic [SBW-1:0]  req_strobe;

   assign mem_op = in_read | in_write;
   assign in_off = in_addr[OFFW-1:0];

   // A 32-bit datapath has no doubleword, so size 3 degrades to a word access.
   always_comb begin
      eff_size = in_size;
      if (XLEN == 32 && in_size == 2'd3) eff_size = 2'd2;
   end

   // Mask is built twice as wide as the strobe so bytes pushed past the top fall off cleanly.
   always_comb begin
      byte_mask    = ((2*SBW)'(1) << ((2*SBW)'(1) << eff_size)) - (2*SBW)'(1);
      shifted_mask = byte_mask << in_off;
      cap_strobe   = shifted_mask[SBW-1:0];
      cap_data     = in_wdata << {in_off, 3'b000};
   end

`ifdef MEM_MISALIGN_EXC_EN
   always_comb begin
      case (eff_size)
         2'd0:    mis = 1'b0;
         2'd1:    mis = in_addr[0];
         2'd2:    mis = |in_addr[1:0];
         default: mis = |in_addr[2:0];
      endcase
   end
`else
   assign mis = 1'b0;
`endif

   assign req_off    = req_addr[OFFW-1:0];
   assign resp_shift = bus_resp_data >> {req_off, 3'b000};

   always_comb begin
      load_ext = resp_shift;
      case (req_size)
         2'd0: load_ext = req_unsigned ? XLEN'(resp_shift[7:0])
                                       : XLEN'(signed'(resp_shift[7:0]));
         2'd1: load_ext = req_unsigned ? XLEN'(resp_shift[15:0])
                                       : XLEN'(signed'(resp_shift[15:0]));
         2'd2: load_ext = req_unsigned ? XLEN'(resp_shift[31:0])
                                       : XLEN'(signed'(resp_shift[31:0]));
         default: load_ext = resp_shift;
      endcase
   end

   // Bus request: a transfer happens on the rising edge where bus_req_valid and bus_req_ready
   // are both high; valid, once raised, stays high with an unchanged payload until that edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         bus_req_valid <= 1'b0;
         out_valid     <= 1'b0;
         out_rdata     <= '0;
         out_misalign  <= 1'b0;
         req_addr      <= '0;
         req_size      <= 2'd0;
         req_unsigned  <= 1'b0;
         req_write     <= 1'b0;
         req_data      <= '0;
         req_strobe    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  out_rdata    <= '0;
                  out_misalign <= 1'b0;
                  if (mem_op) begin
                     req_addr     <= in_addr;
                     req_size     <= eff_size;
                     req_unsigned <= in_unsigned;
                     req_write    <= in_write;
                     req_data     <= cap_data;
                     req_strobe   <= cap_strobe;
                     if (mis) begin
                        state        <= S_DONE;
                        out_valid    <= 1'b1;
                        out_misalign <= 1'b1;
                     end else begin
                        state         <= S_REQ;
                        bus_req_valid <= 1'b1;
                     end
                  end else begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               // A response seen here is not consumed; only the request handshake counts.
               if (bus_req_ready) begin
                  bus_req_valid <= 1'b0;
                  if (req_write) begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (bus_resp_valid) begin
                  out_rdata <= load_ext;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               out_valid <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               state         <= S_IDLE;
               bus_req_valid <= 1'b0;
               out_valid     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready       = (state == S_IDLE);
   assign stall          = (state != S_IDLE) || (in_valid && mem_op);
   assign bus_req_write  = req_write;
   assign bus_req_addr   = req_addr;
   assign bus_req_size   = req_size;
   assign bus_req_data   = req_data;
   assign bus_req_strobe = req_strobe;
   assign dbg_state      = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (XLEN=64); misalign expectations follow MEM_MISALIGN_EXC_EN.
module tb_mem_access_unit;

   localparam int XLEN = 64;
   localparam int SBW  = XLEN / 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_ready, in_read, in_write, in_unsigned;
   logic [1:0]      in_size;
   logic [XLEN-1:0] in_addr, in_wdata;
   logic            bus_req_valid, bus_req_ready, bus_req_write;
   logic [XLEN-1:0] bus_req_addr, bus_req_data;
   logic [1:0]      bus_req_size;
   logic [SBW-1:0]  bus_req_strobe;
   logic            bus_resp_valid;
   logic [XLEN-1:0] bus_resp_data;
   logic            out_valid, out_misalign, stall;
   logic [XLEN-1:0] out_rdata;
   logic [1:0]      dbg_state;

   int total = 0;
   int bad   = 0;
   int hs_count = 0;
   logic [XLEN-1:0] exp_q[$];

   mem_access_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_read(in_read), .in_write(in_write),
      .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_write(bus_req_write),
      .bus_req_addr(bus_req_addr), .bus_req_size(bus_req_size), .bus_req_data(bus_req_data),
      .bus_req_strobe(bus_req_strobe), .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
      .out_valid(out_valid), .out_rdata(out_rdata), .out_misalign(out_misalign), .stall(stall),
      .dbg_state(dbg_state)
   );

   // clock / reset / handshake monitor
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus_req_valid && bus_req_ready) hs_count <= hs_count + 1;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // driver tasks
   task automatic drive_idle();
      in_valid = 1'b0; in_read = 1'b0; in_write = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
      in_addr = '0; in_wdata = '0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", bus_req_valid); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      total++; if (out_misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign: got %b want 0", out_misalign); end
      total++; if (out_rdata !== 64'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", out_rdata); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
      total++; if (bus_req_strobe !== 8'h00) begin bad++; $display("FAIL rst_strobe: got %h want 00", bus_req_strobe); end
      reset = 1'b0;
      @(negedge clk);
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
   endtask

   task automatic test_load(input string tag, input logic [XLEN-1:0] addr, input logic [1:0] size,
                            input logic uns, input logic [XLEN-1:0] resp, input logic [XLEN-1:0] expv,
                            input logic [SBW-1:0] exp_strobe);
      logic [XLEN-1:0] e;
      @(negedge clk);
      in_valid = 1'b1; in_read = 1'b1; in_write = 1'b0; in_size = size; in_unsigned = uns;
      in_addr = addr; bus_req_ready = 1'b1;
      exp_q.push_back(expv);
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s_stall_in: got %b want 1", tag, stall); end
      @(negedge clk);
      in_valid = 1'b0; in_read = 1'b0;
      total++; if (bus_req_valid !== 1'b1) begin bad++; $display("FAIL %s_req_valid: got %b want 1", tag, bus_req_valid); end
      total++; if (bus_req_write !== 1'b0) begin bad++; $display("FAIL %s_req_write: got %b want 0", tag, bus_req_write); end
      total++; if (bus_req_addr !== addr) begin bad++; $display("FAIL %s_req_addr: got %h want %h", tag, bus_req_addr, addr); end
      total++; if (bus_req_strobe !== exp_strobe) begin bad++; $display("FAIL %s_strobe: got %h want %h", tag, bus_req_strobe, exp_strobe); end
      @(negedge clk);
      total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL %s_wait_state: got %0d want 2", tag, dbg_state); end
      total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL %s_req_drop: got %b want 0", tag, bus_req_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid: got %b want 0", tag, out_valid); end
      bus_resp_valid = 1'b1; bus_resp_data = resp;
      @(negedge clk);
      bus_resp_valid = 1'b0; bus_resp_data = '0;
      e = exp_q.pop_front();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_out_valid: got %b want 1", tag, out_valid); end
      total++; if (out_rdata !== e) begin bad++; $display("FAIL %s_rdata: got %h want %h", tag, out_rdata, e); end
      total++; if (out_misalign !== 1'b0) begin bad++; $display("FAIL %s_misalign: got %b want 0", tag, out_misalign); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_one_cycle: got %b want 0", tag, out_valid); end
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL %s_idle: got %0d want 0", tag, dbg_state); end
      bus_req_ready = 1'b0;
   endtask

   task automatic test_store(input string tag, input logic [XLEN-1:0] addr, input logic [1:0] size,
                             input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] exp_data,
                             input logic [SBW-1:0] exp_strobe);
      @(negedge clk);
      in_valid = 1'b1; in_write = 1'b1; in_read = 1'b0; in_size = size; in_addr = addr;
      in_wdata = wdata; bus_req_ready = 1'b1;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s_stall_in: got %b want 1", tag, stall); end
      @(negedge clk);
      in_valid = 1'b0; in_write = 1'b0;
      total++; if (bus_req_valid !== 1'b1) begin bad++; $display("FAIL %s_req_valid: got %b want 1", tag, bus_req_valid); end
      total++; if (bus_req_write !== 1'b1) begin bad++; $display("FAIL %s_req_write: got %b want 1", tag, bus_req_write); end
      total++; if (bus_req_data !== exp_data) begin bad++; $display("FAIL %s_data: got %h want %h", tag, bus_req_data, exp_data); end
      total++; if (bus_req_strobe !== exp_strobe) begin bad++; $display("FAIL %s_strobe: got %h want %h", tag, bus_req_strobe, exp_strobe); end
      total++; if (bus_req_size !== size) begin bad++; $display("FAIL %s_size: got %0d want %0d", tag, bus_req_size, size); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_out_valid: got %b want 1", tag, out_valid); end
      total++; if (out_rdata !== 64'h0) begin bad++; $display("FAIL %s_rdata: got %h want 0", tag, out_rdata); end
      total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL %s_req_drop: got %b want 0", tag, bus_req_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_one_cycle: got %b want 0", tag, out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_back: got %b want 1", tag, in_ready); end
      bus_req_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int hs0;
      hs0 = hs_count;
      @(negedge clk);
      in_valid = 1'b1; in_write = 1'b1; in_size = 2'd2; in_addr = 64'h3008;
      in_wdata = 64'hCAFE_F00D; bus_req_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; in_write = 1'b0; in_wdata = 64'h5555_5555;
      for (int i = 0; i < 4; i++) begin
         total++; if (bus_req_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus_req_valid); end
         total++; if (bus_req_addr !== 64'h3008) begin bad++; $display("FAIL bp_addr[%0d]: got %h want 3008", i, bus_req_addr); end
         total++; if (bus_req_data !== 64'hCAFE_F00D) begin bad++; $display("FAIL bp_data[%0d]: got %h want cafef00d", i, bus_req_data); end
         total++; if (bus_req_strobe !== 8'h0F) begin bad++; $display("FAIL bp_strobe[%0d]: got %h want 0f", i, bus_req_strobe); end
         total++; if (stall !== 1'b1) begin bad++; $display("FAIL bp_stall[%0d]: got %b want 1", i, stall); end
         @(negedge clk);
      end
      total++; if (bus_req_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_end: got %b want 1", bus_req_valid); end
      bus_req_ready = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
      total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_drop: got %b want 0", bus_req_valid); end
      @(negedge clk);
      bus_req_ready = 1'b0;
      total++; if (hs_count - hs0 !== 1) begin bad++; $display("FAIL bp_handshakes: got %0d want 1", hs_count - hs0); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      in_valid = 1'b1; in_write = 1'b1; in_size = 2'd0; in_addr = 64'h4000;
      in_wdata = 64'h11; bus_req_ready = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_req: got %b want 0", in_ready); end
      total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL b2b_state_req: got %0d want 1", dbg_state); end
      in_size = 2'd1; in_addr = 64'h4012; in_wdata = 64'hBEEF;
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_done: got %b want 0", in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid_a: got %b want 1", out_valid); end
      @(negedge clk);
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL b2b_state_idle: got %0d want 0", dbg_state); end
      total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_req: got %b want 0", bus_req_valid); end
      @(negedge clk);
      in_valid = 1'b0; in_write = 1'b0;
      total++; if (bus_req_addr !== 64'h4012) begin bad++; $display("FAIL b2b_addr_b: got %h want 4012", bus_req_addr); end
      total++; if (bus_req_strobe !== 8'h0C) begin bad++; $display("FAIL b2b_strobe_b: got %h want 0c", bus_req_strobe); end
      total++; if (bus_req_data !== 64'hBEEF_0000) begin bad++; $display("FAIL b2b_data_b: got %h want beef0000", bus_req_data); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid_b: got %b want 1", out_valid); end
      @(negedge clk);
      bus_req_ready = 1'b0;
   endtask

   task automatic test_non_mem();
      int hs0;
      hs0 = hs_count;
      @(negedge clk);
      in_valid = 1'b1; in_read = 1'b0; in_write = 1'b0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL nm_stall: got %b want 0", stall); end
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL nm_out_valid: got %b want 1", out_valid); end
      total++; if (out_rdata !== 64'h0) begin bad++; $display("FAIL nm_rdata: got %h want 0", out_rdata); end
      total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL nm_req_valid: got %b want 0", bus_req_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nm_one_cycle: got %b want 0", out_valid); end
      total++; if (hs_count !== hs0) begin bad++; $display("FAIL nm_no_bus: got %0d want %0d", hs_count, hs0); end
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      in_valid = 1'b1; in_read = 1'b1; in_size = 2'd0; in_unsigned = 1'b0;
      in_addr = 64'h1000; bus_req_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_read = 1'b0;
      @(negedge clk);
      total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL rw_in_wait: got %0d want 2", dbg_state); end
      reset = 1'b1;
      #1;
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rw_async_state: got %0d want 0", dbg_state); end
      total++; if (out_rdata !== 64'h0) begin bad++; $display("FAIL rw_rdata_clr: got %h want 0", out_rdata); end
      total++; if (bus_req_addr !== 64'h0) begin bad++; $display("FAIL rw_reqreg_clr: got %h want 0", bus_req_addr); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rw_stall: got %b want 0", stall); end
      @(negedge clk);
      reset = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'hFF;
      @(negedge clk);
      bus_resp_valid = 1'b0; bus_resp_data = '0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rw_out_valid: got %b want 0", out_valid); end
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rw_state: got %0d want 0", dbg_state); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rw_in_ready: got %b want 1", in_ready); end
      @(negedge clk);
      bus_req_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rw_out_valid_late: got %b want 0", out_valid); end
   endtask

   task automatic test_misalign();
`ifdef MEM_MISALIGN_EXC_EN
      int hs0;
      hs0 = hs_count;
      @(negedge clk);
      in_valid = 1'b1; in_read = 1'b1; in_size = 2'd2; in_unsigned = 1'b0;
      in_addr = 64'h1002; bus_req_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_read = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mis_out_valid: got %b want 1", out_valid); end
      total++; if (out_misalign !== 1'b1) begin bad++; $display("FAIL mis_flag: got %b want 1", out_misalign); end
      total++; if (out_rdata !== 64'h0) begin bad++; $display("FAIL mis_rdata: got %h want 0", out_rdata); end
      total++; if (bus_req_valid !== 1'b0) begin bad++; $display("FAIL mis_req_valid: got %b want 0", bus_req_valid); end
      @(negedge clk);
      bus_req_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mis_one_cycle: got %b want 0", out_valid); end
      total++; if (hs_count !== hs0) begin bad++; $display("FAIL mis_no_bus: got %0d want %0d", hs_count, hs0); end
`else
      test_load("mis_off", 64'h1002, 2'd2, 1'b0, 64'h0000_0000_CAFE_0000, 64'h0000_0000_0000_CAFE, 8'h3C);
`endif
   endtask

   initial begin
      test_reset();
      test_load("lb",  64'h1003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h08);
      test_load("lbu", 64'h1003, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 8'h08);
      test_load("lh",  64'h1006, 2'd1, 1'b0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 8'hC0);
      test_load("lhu", 64'h1002, 2'd1, 1'b1, 64'h0000_0000_7FFF_0000, 64'h0000_0000_0000_7FFF, 8'h0C);
      test_load("lw",  64'h1004, 2'd2, 1'b0, 64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_DEAD_BEEF, 8'hF0);
      test_load("lwu", 64'h1004, 2'd2, 1'b1, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, 8'hF0);
      test_load("ld",  64'h1000, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'hFF);
      test_non_mem();
      test_store("sh", 64'h2006, 2'd1, 64'hBEEF, 64'hBEEF_0000_0000_0000, 8'hC0);
      test_store("sb", 64'h2001, 2'd0, 64'hA5, 64'h0000_0000_0000_A500, 8'h02);
      test_store("sw", 64'h2004, 2'd2, 64'h1234_5678, 64'h1234_5678_0000_0000, 8'hF0);
      test_store("sd", 64'h2000, 2'd3, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 8'hFF);
      test_backpressure();
      test_back_to_back();
      test_load("lb2", 64'h1001, 2'd0, 1'b0, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F, 8'h02);
      test_reset_in_wait();
      test_misalign();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter SBW, default XLEN/8, byte-strobe width; derived, not overridden.
REQ-003 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: in_valid  in  1  memory-stage op presented; in_ready  out  1  op accepted this cycle.
REQ-006 SHALL have ports: in_read  in  1  load; in_write  in  1  store; in_size  in  2  0=B,1=H,2=W,3=D; in_unsigned  in  1  zero-extend load.
REQ-007 SHALL have ports: in_addr  in  XLEN  effective address; in_wdata  in  XLEN  unaligned store data (LSB-justified).
REQ-008 SHALL have ports: bus_req_valid  out  1; bus_req_ready  in  1; bus_req_write  out  1; bus_req_addr  out  XLEN; bus_req_size  out  2; bus_req_data  out  XLEN; bus_req_strobe  out  SBW.
REQ-009 SHALL have ports: bus_resp_valid  in  1; bus_resp_data  in  XLEN  naturally-aligned word containing the access.
REQ-010 SHALL have ports: out_valid  out  1; out_rdata  out  XLEN  extended load result; out_misalign  out  1; stall  out  1  hold upstream pipeline.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT, DONE; only IDLE asserts in_ready.
REQ-012 SHALL, in IDLE with in_valid and (in_read or in_write), capture addr/size/unsigned/write/shifted data/strobe into a request register and go to REQ.
REQ-013 SHALL, in IDLE with in_valid and neither read nor write, go directly to DONE with out_rdata=0 and no bus activity (1-cycle latency).
REQ-014 SHALL hold bus_req_valid high in REQ with stable payload until bus_req_ready; on handshake go to WAIT for reads, DONE for writes.
REQ-015 SHALL, in WAIT, ignore bus_resp_valid low; on bus_resp_valid high capture extended data and go to DONE.
REQ-016 SHALL assert out_valid for exactly one cycle in DONE, then return to IDLE; out_rdata/out_misalign stable while out_valid.
REQ-017 SHALL form strobe = ((1<<(1<<size))-1) << addr[log2(SBW)-1:0] and bus_req_data = in_wdata << 8*addr offset.
REQ-018 SHALL extract load data by shifting bus_resp_data right by 8*addr offset, then sign- or zero-extend from 8/16/32 bits per in_size/in_unsigned; size 3 passes through.
REQ-019 SHALL treat size 3 with XLEN=32 as size 2.
REQ-020 SHALL drive stall = (state != IDLE) or (in_valid and memory op in IDLE), combinationally.
REQ-021 SHALL accept bus_req_ready and bus_resp_valid in the same cycle only as the REQ handshake; a response in REQ is not consumed.
REQ-022 SHALL not accept a new op in DONE; back-to-back ops take minimum 3 cycles (IDLE->REQ->DONE) for stores with ready=1.

Reset
REQ-023 SHALL, on reset assertion at any time including mid-transaction, go to IDLE immediately, deassert bus_req_valid, out_valid, out_misalign, stall-from-state, clear out_rdata and request register to 0.
REQ-024 SHALL drop any outstanding bus response arriving after reset release (WAIT is abandoned, not resumed).

Configuration
REQ-025 SHALL, with MEM_MISALIGN_EXC_EN defined, detect addr not a multiple of access size at capture, skip REQ, go to DONE with out_misalign=1, out_rdata=0, no bus transaction.
REQ-026 SHALL, without MEM_MISALIGN_EXC_EN, tie out_misalign to 0 and issue misaligned accesses as-is (strobe bits beyond SBW truncated).

Verification
REQ-027 Load: XLEN=64, lb addr=0x1003, resp_data=0x0000_0000_8000_0000 -> out_rdata=0xFFFF_FFFF_FFFF_FF80 with lbu -> 0x80, out_valid one cycle after resp.
REQ-028 Store: sh addr=0x2006, wdata=0xBEEF, ready=1 -> bus_req_strobe=0xC0, bus_req_data=0xBEEF_0000_0000_0000, out_valid 2 cycles after accept.
REQ-029 Backpressure: bus_req_ready low 4 cycles -> bus_req_valid/payload held stable, stall high throughout, single handshake.
REQ-030 Reset in WAIT: assert reset, release, then resp_valid=1 -> no out_valid, state IDLE, in_ready=1.
REQ-031 Misalign (macro on): lw addr=0x1002 -> no bus_req_valid, out_valid=1 with out_misalign=1 next cycle; macro off -> bus request issued, strobe=0x3C.
REQ-032 Non-memory op: in_valid with read=write=0 -> out_valid next cycle, out_rdata=0, bus_req_valid never asserted.
